// File: rtl/seven_segment_counter_mux.sv
// ---------------------------------------------------------------------------
// seven_segment_counter_mux
//
// Multi-digit BCD up/down counter driving a time-multiplexed common-cathode
// seven-segment display.  A prescaler produces one count step every
// TICK_COUNT clock cycles while run is high; a free-running refresh counter
// walks the display through the digits every REFRESH_COUNT cycles.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   run         1 = prescaler and counter advance, 0 = both hold
//   up_down     1 = count up, 0 = count down (sampled on each step)
//   load        synchronous load strobe (wins over a simultaneous step)
//   load_value  BCD load data, nibble 0 = least significant digit
//   count_bcd   current BCD count
//   segments    active-high segments for the selected digit (bit0=a..bit6=g)
//   digit_sel   one-hot active-high digit enable
//   tick        one-cycle pulse when the count changes by counting
//   rollover    one-cycle pulse on wrap (up: max->0, down: 0->max)
//
// No handshakes: every input is sampled on each rising clk edge and all
// outputs are registered.
// ---------------------------------------------------------------------------
module seven_segment_counter_mux #(
    parameter int TICK_COUNT    = 10_000_000,
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_COUNT = 10_000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    up_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    tick,
    output logic                    rollover
);

    localparam int PRE_W = $clog2(TICK_COUNT);
    localparam int REF_W = $clog2(REFRESH_COUNT);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_COUNT - 1);
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        prescaler;
    logic [REF_W-1:0]        refresh;
    logic [IDX_W-1:0]        mux_idx;

    logic                    step;
    logic                    wrap;
    logic                    carry;
    logic [3:0]              digit;
    logic [4*NUM_DIGITS-1:0] next_count;
    logic [4*NUM_DIGITS-1:0] load_clamped;
    logic [3:0]              sel_digit;
    logic                    zero_above;
    logic                    blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    assign step = run && (prescaler == PRE_MAX);

    // BCD ripple: carry means "every lower digit was at its wrap value",
    // so it starts at 1 for digit 0.  A carry out of the top digit is a wrap.
    always_comb begin
        next_count = count_bcd;
        carry      = 1'b1;
        digit      = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = count_bcd[4*i +: 4];
            if (carry) begin
                if (up_down) begin
                    if (digit >= 4'd9) begin
                        next_count[4*i +: 4] = 4'd0;
                    end else begin
                        next_count[4*i +: 4] = digit + 4'd1;
                        carry                = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        next_count[4*i +: 4] = 4'd9;
                    end else begin
                        next_count[4*i +: 4] = digit - 4'd1;
                        carry                = 1'b0;
                    end
                end
            end
        end
        wrap = carry;
    end

    // Out-of-range load nibbles saturate to 9 so a digit never holds 10..15.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9
                                                                   : load_value[4*i +: 4];
        end
    end

    // Selected digit plus leading-zero detection: the digit is blanked when
    // it and every higher digit are zero (digit 0 always shows).
    always_comb begin
        sel_digit  = 4'd0;
        zero_above = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == mux_idx) begin
                sel_digit = count_bcd[4*i +: 4];
            end
            if ((IDX_W'(i) >= mux_idx) && (count_bcd[4*i +: 4] != 4'd0)) begin
                zero_above = 1'b0;
            end
        end
        blank = BLANK_LEADING && (mux_idx != '0) && zero_above;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_bcd <= '0;
            prescaler <= '0;
            refresh   <= '0;
            mux_idx   <= '0;
            digit_sel <= NUM_DIGITS'(1);
            segments  <= 7'h3F;
            tick      <= 1'b0;
            rollover  <= 1'b0;
        end else begin
            if (load) begin
                count_bcd <= load_clamped;
                prescaler <= '0;
                tick      <= 1'b0;
                rollover  <= 1'b0;
            end else if (step) begin
                count_bcd <= next_count;
                prescaler <= '0;
                tick      <= 1'b1;
                rollover  <= wrap;
            end else begin
                tick      <= 1'b0;
                rollover  <= 1'b0;
                if (run) begin
                    prescaler <= prescaler + PRE_W'(1);
                end
            end

            // Display refresh runs regardless of run.
            if (refresh == REF_MAX) begin
                refresh <= '0;
                mux_idx <= (mux_idx == IDX_MAX) ? '0 : mux_idx + IDX_W'(1);
            end else begin
                refresh <= refresh + REF_W'(1);
            end

            digit_sel <= NUM_DIGITS'(1) << mux_idx;
            segments  <= blank ? 7'h00 : decode(sel_digit);
        end
    end

endmodule
